// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr decode, trap/mret sequencing, 64-bit cycle/instret counters (CSR_COUNTERS_EN).
// Latency: csr_rdata/csr_illegal are combinational; all state updates land on the next rising clk edge.
// Backpressure: none; accesses are accepted every cycle; trap beats mret, which beats the CSR write.
module csr_file #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  HART_ID     = '0,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [2:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [4:0]      csr_uimm,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instret,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            mie_out
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MISA_VAL   = 32'h4000_0100;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] mstatus_rd;
    logic            mapped;
    logic            read_only;
    logic            wr_intent;
    logic            op_bad;
    logic            do_write;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
`else
    logic counters_unused;
    assign counters_unused = instret;
`endif

    always_comb begin
        mstatus_rd     = 32'h0000_1800;
        mstatus_rd[7]  = mpie;
        mstatus_rd[3]  = mie;
    end

    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:   old_val = mstatus_rd;
            ADDR_MISA:      old_val = MISA_VAL;
            ADDR_MTVEC:     old_val = mtvec;
            ADDR_MSCRATCH:  old_val = mscratch;
            ADDR_MEPC:      old_val = mepc;
            ADDR_MCAUSE:    old_val = mcause;
            ADDR_MHARTID:   old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE,   ADDR_CYCLE:    old_val = mcycle[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   old_val = mcycle[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  old_val = minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: old_val = minstret[63:32];
`endif
            default:        mapped = 1'b0;
        endcase
    end

    always_comb begin
        operand   = csr_op[2] ? {{(XLEN-5){1'b0}}, csr_uimm} : csr_wdata;
        read_only = (csr_addr[11:10] == 2'b11) || (csr_addr == ADDR_MISA);
        op_bad    = (csr_op[1:0] == 2'b00);
        // Set/clear forms with a zero operand are pure reads and may touch read-only CSRs.
        wr_intent = (csr_op[1:0] == 2'b01) || (operand != '0);
        case (csr_op[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_val | operand;
            2'b11:   new_val = old_val & ~operand;
            default: new_val = old_val;
        endcase
    end

    assign csr_illegal = csr_valid && (!mapped || op_bad || (wr_intent && read_only));
    assign csr_rdata   = csr_illegal ? '0 : old_val;
    assign do_write    = csr_valid && !csr_illegal && wr_intent && !trap_valid && !mret;

    assign mtvec_out = mtvec;
    assign mepc_out  = mepc;
    assign mie_out   = mie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (trap_valid) begin
            mepc   <= trap_pc & ALIGN_MASK;
            mcause <= trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (do_write) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie  <= new_val[3];
                    mpie <= new_val[7];
                end
                ADDR_MTVEC:    mtvec    <= new_val & ALIGN_MASK;
                ADDR_MSCRATCH: mscratch <= new_val;
                ADDR_MEPC:     mepc     <= new_val & ALIGN_MASK;
                ADDR_MCAUSE:   mcause   <= new_val;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to either half replaces the whole 64-bit increment for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle <= '0;
        end else if (do_write && csr_addr == ADDR_MCYCLE) begin
            mcycle[31:0] <= new_val;
        end else if (do_write && csr_addr == ADDR_MCYCLEH) begin
            mcycle[63:32] <= new_val;
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minstret <= '0;
        end else if (do_write && csr_addr == ADDR_MINSTRET) begin
            minstret[31:0] <= new_val;
        end else if (do_write && csr_addr == ADDR_MINSTRETH) begin
            minstret[63:32] <= new_val;
        end else if (instret) begin
            minstret <= minstret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file; counter checks follow CSR_COUNTERS_EN of the build.
`timescale 1ns/1ps
module tb_csr_file;

    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;
    localparam logic [2:0] OP_RSI = 3'b110;
    localparam logic [2:0] OP_RCI = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic [2:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [4:0]  csr_uimm = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic        mret = 1'b0;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    int errors = 0;
    int checks = 0;

    csr_file #(.XLEN(32), .HART_ID(32'd3), .MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_uimm(csr_uimm),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instret(instret),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret(mret), .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one CSR access for the coming rising edge; outputs are sampled 1ns after the falling edge.
    task automatic access(input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [4:0] ui = 5'd0,
                          input logic ir = 1'b0);
        @(negedge clk);
        csr_valid  = 1'b1;
        csr_op     = op;
        csr_addr   = addr;
        csr_wdata  = wd;
        csr_uimm   = ui;
        instret    = ir;
        trap_valid = 1'b0;
        mret       = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        access(OP_RS, 12'h300, 32'h0);
        checks++; if (csr_rdata !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %h want %h", csr_rdata, 32'h1800); end
        checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL reset_mtvec_out: got %h want %h", mtvec_out, 32'h100); end
        checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL reset_mie: got %b want 0", mie_out); end
        access(OP_RS, 12'h305, 32'h0);
        checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL reset_read_mtvec: got %h want %h", csr_rdata, 32'h100); end
        @(negedge clk);
        rst = 1'b0;
        csr_op = OP_RS; csr_addr = 12'hB00; csr_wdata = 32'h0;
        #1;
`ifdef CSR_COUNTERS_EN
        checks++; if (csr_rdata !== 32'd0 || csr_illegal !== 1'b0) begin errors++; $display("FAIL mcycle_first: got %h ill=%b want 0", csr_rdata, csr_illegal); end
        access(OP_RS, 12'hB00, 32'h0);
        checks++; if (csr_rdata !== 32'd1) begin errors++; $display("FAIL mcycle_second: got %h want 1", csr_rdata); end
`else
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'd0) begin errors++; $display("FAIL mcycle_unmapped: ill=%b rdata=%h want 1/0", csr_illegal, csr_rdata); end
`endif
        access(OP_RS, 12'h301, 32'h0);
        checks++; if (csr_rdata !== 32'h4000_0100) begin errors++; $display("FAIL misa: got %h want 40000100", csr_rdata); end
        access(OP_RS, 12'hF14, 32'h0);
        checks++; if (csr_rdata !== 32'd3 || csr_illegal !== 1'b0) begin errors++; $display("FAIL mhartid: got %h ill=%b want 3/0", csr_rdata, csr_illegal); end
    endtask

    task automatic test_rw_set_clear();
        access(OP_RW, 12'h340, 32'hDEAD_BEEF);
        checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin errors++; $display("FAIL rw_old: got %h ill=%b want 0/0", csr_rdata, csr_illegal); end
        access(OP_RS, 12'h340, 32'h10);
        checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_read: got %h want DEADBEEF", csr_rdata); end
        access(OP_RC, 12'h340, 32'h0F);
        checks++; if (csr_rdata !== 32'hDEAD_BEFF) begin errors++; $display("FAIL rc_read: got %h want DEADBEFF", csr_rdata); end
        access(OP_RS, 12'h340, 32'h0);
        checks++; if (csr_rdata !== 32'hDEAD_BEF0) begin errors++; $display("FAIL rc_result: got %h want DEADBEF0", csr_rdata); end
        access(OP_RWI, 12'h342, 32'hFFFF_FFFF, 5'h15);
        access(OP_RCI, 12'h342, 32'hFFFF_FFFF, 5'h05);
        checks++; if (csr_rdata !== 32'h15) begin errors++; $display("FAIL rwi_uimm: got %h want 15", csr_rdata); end
        access(OP_RSI, 12'h342, 32'hFFFF_FFFF, 5'h00);
        checks++; if (csr_rdata !== 32'h10) begin errors++; $display("FAIL rci_result: got %h want 10", csr_rdata); end
    endtask

    task automatic test_illegal();
        access(OP_RW, 12'hC00, 32'd5);
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'd0) begin errors++; $display("FAIL rw_cycle: ill=%b rdata=%h want 1/0", csr_illegal, csr_rdata); end
        access(OP_RW, 12'hF14, 32'd5);
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'd0) begin errors++; $display("FAIL rw_mhartid: ill=%b rdata=%h want 1/0", csr_illegal, csr_rdata); end
        access(OP_RS, 12'hF14, 32'd0);
        checks++; if (csr_rdata !== 32'd3) begin errors++; $display("FAIL mhartid_kept: got %h want 3", csr_rdata); end
        access(3'b000, 12'h340, 32'd0);
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL op000: ill=%b want 1", csr_illegal); end
        access(3'b100, 12'h340, 32'h1234);
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL op100: ill=%b want 1", csr_illegal); end
        access(OP_RC, 12'h301, 32'd1);
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL rc_misa: ill=%b want 1", csr_illegal); end
        access(OP_RW, 12'h123, 32'd0);
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL unmapped: ill=%b want 1", csr_illegal); end
        access(OP_RS, 12'h340, 32'h0);
        checks++; if (csr_rdata !== 32'hDEAD_BEF0) begin errors++; $display("FAIL illegal_no_change: got %h want DEADBEF0", csr_rdata); end
        @(negedge clk);
        csr_valid = 1'b0; csr_op = OP_RW; csr_addr = 12'h123;
        #1;
        checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL illegal_unqualified: ill=%b want 0", csr_illegal); end
        access(OP_RS, 12'hC00, 32'd0);
`ifdef CSR_COUNTERS_EN
        checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL rs0_cycle_legal: ill=%b want 0", csr_illegal); end
`else
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL rs0_cycle_unmapped: ill=%b want 1", csr_illegal); end
`endif
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        access(OP_RW, 12'hB00, 32'd10);
        access(OP_RW, 12'hB80, 32'd0);
        access(OP_RS, 12'hC00, 32'd0);
        checks++; if (csr_rdata !== 32'd10 || csr_illegal !== 1'b0) begin errors++; $display("FAIL cycle_shadow: got %h ill=%b want a/0", csr_rdata, csr_illegal); end
        access(OP_RS, 12'hC80, 32'd0);
        checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL cycleh_shadow: got %h want 0", csr_rdata); end
        access(OP_RW, 12'hB00, 32'hFFFF_FFFF);
        access(OP_RW, 12'hB80, 32'd0);
        access(OP_RS, 12'hB00, 32'd0);
        checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_held: got %h want FFFFFFFF", csr_rdata); end
        access(OP_RS, 12'hB80, 32'd0);
        checks++; if (csr_rdata !== 32'd1) begin errors++; $display("FAIL mcycleh_carry: got %h want 1", csr_rdata); end
        access(OP_RS, 12'hB00, 32'd0);
        checks++; if (csr_rdata !== 32'd1) begin errors++; $display("FAIL mcycle_after_carry: got %h want 1", csr_rdata); end
        access(OP_RW, 12'hB02, 32'd5, 5'd0, 1'b1);
        access(OP_RS, 12'hB02, 32'd0, 5'd0, 1'b1);
        checks++; if (csr_rdata !== 32'd5) begin errors++; $display("FAIL minstret_write_wins: got %h want 5", csr_rdata); end
        access(OP_RS, 12'hC02, 32'd0);
        checks++; if (csr_rdata !== 32'd6) begin errors++; $display("FAIL minstret_incr: got %h want 6", csr_rdata); end
        access(OP_RS, 12'hB02, 32'd0);
        checks++; if (csr_rdata !== 32'd6) begin errors++; $display("FAIL minstret_idle: got %h want 6", csr_rdata); end
        access(OP_RW, 12'hB02, 32'hFFFF_FFFF);
        access(OP_RW, 12'hB82, 32'hFFFF_FFFF);
        access(OP_RS, 12'hC82, 32'd0, 5'd0, 1'b1);
        checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL minstreth_pre_wrap: got %h want FFFFFFFF", csr_rdata); end
        access(OP_RS, 12'hB82, 32'd0);
        checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL minstreth_wrap: got %h want 0", csr_rdata); end
        access(OP_RS, 12'hB02, 32'd0);
        checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL minstret_wrap: got %h want 0", csr_rdata); end
`else
        access(OP_RW, 12'hB82, 32'd1, 5'd0, 1'b1);
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL minstreth_unmapped: ill=%b want 1", csr_illegal); end
        access(OP_RS, 12'hC02, 32'd0);
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'd0) begin errors++; $display("FAIL instret_unmapped: ill=%b rdata=%h want 1/0", csr_illegal, csr_rdata); end
`endif
    endtask

    task automatic test_trap();
        access(OP_RSI, 12'h300, 32'd0, 5'd8);
        @(negedge clk);
        csr_valid = 1'b0; trap_valid = 1'b1; trap_pc = 32'h1006; trap_cause = 32'd11;
        #1;
        checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL mie_set: got %b want 1", mie_out); end
        access(OP_RS, 12'h342, 32'd0);
        checks++; if (csr_rdata !== 32'd11) begin errors++; $display("FAIL trap_mcause: got %h want b", csr_rdata); end
        checks++; if (mepc_out !== 32'h1004) begin errors++; $display("FAIL trap_mepc: got %h want 1004", mepc_out); end
        checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL trap_mie: got %b want 0", mie_out); end
        access(OP_RS, 12'h300, 32'd0);
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL trap_mstatus: got %h want 1880", csr_rdata); end
        @(negedge clk);
        csr_valid = 1'b0; mret = 1'b1;
        #1;
        access(OP_RS, 12'h300, 32'd0);
        checks++; if (csr_rdata !== 32'h1888 || mie_out !== 1'b1) begin errors++; $display("FAIL mret_mstatus: got %h mie=%b want 1888/1", csr_rdata, mie_out); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        csr_valid = 1'b1; csr_op = OP_RW; csr_addr = 12'h340; csr_wdata = 32'h1234_5678;
        trap_valid = 1'b1; trap_pc = 32'h2000; trap_cause = 32'd7; mret = 1'b1;
        #1;
        checks++; if (csr_rdata !== 32'hDEAD_BEF0 || csr_illegal !== 1'b0) begin errors++; $display("FAIL prio_read_old: got %h ill=%b want DEADBEF0/0", csr_rdata, csr_illegal); end
        access(OP_RS, 12'h340, 32'd0);
        checks++; if (csr_rdata !== 32'hDEAD_BEF0) begin errors++; $display("FAIL prio_mscratch_kept: got %h want DEADBEF0", csr_rdata); end
        checks++; if (mepc_out !== 32'h2000 || mie_out !== 1'b0) begin errors++; $display("FAIL prio_trap_applied: mepc=%h mie=%b want 2000/0", mepc_out, mie_out); end
        @(negedge clk);
        csr_valid = 1'b1; csr_op = OP_RW; csr_addr = 12'h300; csr_wdata = 32'd0;
        trap_valid = 1'b0; mret = 1'b1;
        #1;
        access(OP_RS, 12'h300, 32'd0);
        checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_beats_write: got %h want 1888", csr_rdata); end
    endtask

    task automatic test_back_to_back();
        access(OP_RW, 12'h341, 32'h1237);
        access(OP_RW, 12'h305, 32'h0000_0203);
        checks++; if (mepc_out !== 32'h1234) begin errors++; $display("FAIL mepc_align: got %h want 1234", mepc_out); end
        checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL mtvec_old: got %h want 100", csr_rdata); end
        access(OP_RS, 12'h305, 32'd0);
        checks++; if (csr_rdata !== 32'h200 || mtvec_out !== 32'h200) begin errors++; $display("FAIL mtvec_raw: got %h out=%h want 200", csr_rdata, mtvec_out); end
        access(OP_RS, 12'h341, 32'd0);
        checks++; if (csr_rdata !== 32'h1234) begin errors++; $display("FAIL mepc_read: got %h want 1234", csr_rdata); end
    endtask

    task automatic test_reset_midop();
        access(OP_RW, 12'h340, 32'h55);
        rst = 1'b1;
        #1;
        checks++; if (mie_out !== 1'b0 || mtvec_out !== 32'h100 || mepc_out !== 32'h0) begin errors++; $display("FAIL async_reset: mie=%b mtvec=%h mepc=%h want 0/100/0", mie_out, mtvec_out, mepc_out); end
        @(negedge clk);
        rst = 1'b0;
        csr_valid = 1'b1; csr_op = OP_RS; csr_addr = 12'h340; csr_wdata = 32'd0;
        #1;
        checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_drops_write: got %h want 0", csr_rdata); end
    endtask

    initial begin
        test_reset();
        test_rw_set_clear();
        test_illegal();
        test_counters();
        test_trap();
        test_priority();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode Control and Status Register file for the RV32 core, replacing the stub CSR block. It decodes Zicsr accesses (read/write, set, clear, immediate forms), holds the trap-handling CSRs, and runs the 64-bit cycle and retired-instruction counters. It also sequences trap entry and `mret` state updates. It sits beside the register file in the execute stage and feeds `mtvec` and `mepc` to the fetch redirect logic.

## Interface
- `XLEN`, 32: data width; only 32 is supported, and counters are split into low and high halves.
- `HART_ID`, 0: value read from `mhartid`.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `csr_valid`  in  1  CSR instruction present this cycle.
- `csr_op`  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000 and 100 are illegal.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  XLEN  rs1 value for register forms.
- `csr_uimm`  in  5  zero-extended immediate for immediate forms.
- `csr_rdata`  out  XLEN  old CSR value (combinational).
- `csr_illegal`  out  1  access fault (combinational); qualified by `csr_valid`.
- `instret`  in  1  one instruction retired this cycle.
- `trap_valid`  in  1  take trap this cycle.
- `trap_cause`  in  XLEN  value for `mcause`.
- `trap_pc`  in  XLEN  PC of the faulting instruction.
- `mret`  in  1  return from trap.
- `mtvec_out`, `mepc_out`  out  XLEN  current register values.
- `mie_out`  out  1  current `mstatus.MIE`.

## Operation
- Address map:
  - `mstatus` 0x300: MIE is bit 3, MPIE is bit 7. MPP (bits 12:11) reads as 2'b11. All other bits read 0 and ignore writes.
  - `misa` 0x301: reads 32'h4000_0100.
  - `mtvec` 0x305: bits 1:0 are forced to 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bits 1:0 are forced to 0.
  - `mcause` 0x342.
  - Counters: `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82.
  - Read-only user shadows: `cycle`/`cycleh` 0xC00/0xC80 and `instret`/`instreth` 0xC02/0xC82.
  - `mhartid` 0xF14.
- Operand selection: `csr_wdata` for the register forms; `{27'b0, csr_uimm}` for the immediate forms.
- New value by operation:
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
- Write intent:
  - RW and RWI always intend to write.
  - RS, RC, RSI and RCI intend to write only if the operand is nonzero.
- `csr_illegal` is 1 when `csr_valid` is high and any of the following holds:
  - the address is unmapped;
  - `csr_op` is 000 or 100;
  - a write is intended to a read-only address (`addr[11:10]` == 2'b11, or `misa`).
- An illegal access changes no state, and `csr_rdata` reads 0.
- Trap entry on `trap_valid`:
  - `mepc` <= `trap_pc` & ~3;
  - `mcause` <= `trap_cause`;
  - MPIE <= MIE;
  - MIE <= 0.
- `mret`: MIE <= MPIE; MPIE <= 1.
- Same-cycle priority:
  - `trap_valid` beats `mret`, and `mret` beats the CSR write.
  - A suppressed CSR write is dropped silently, but its read still returns the old value.
- `mcycle` increments every cycle. `minstret` increments when `instret` is 1. The carry from the low half propagates into the high half in the same cycle.
- A CSR write to either half of a counter replaces that cycle's increment of the whole 64-bit counter. The other half holds its value.

## Timing
- `csr_rdata` and `csr_illegal` are combinational from `csr_addr`, `csr_op` and the operands in the same cycle.
- Writes, trap and `mret` updates become visible on the next rising edge, with 1-cycle latency.
- A read-after-write on consecutive cycles returns the new value.
- Reset values while `rst` is high, asynchronously:
  - `mstatus` reads 32'h0000_1800;
  - `mtvec` = `MTVEC_RESET`;
  - `mscratch`, `mepc`, `mcause` = 0;
  - counters = 0;
  - `mie_out` = 0.
- `mcycle` reads 0 in the first cycle after reset deasserts and 1 in the next cycle.
- Counter wrap: 64'hFFFF_FFFF_FFFF_FFFF + 1 becomes 0 with no flag.
- Reset mid-operation discards the pending write.

## Configuration
- `CSR_COUNTERS_EN` defined: the counter registers and all 8 counter addresses exist as described above.
- `CSR_COUNTERS_EN` undefined:
  - no counter flops are built, and `instret` is ignored;
  - all counter addresses are unmapped, so any access raises `csr_illegal`.

## Test plan
- Reset released: read 0x300 -> 32'h1800; read 0x305 -> `MTVEC_RESET`; `mie_out` = 0.
- CSRRW 0x340 with 32'hDEAD_BEEF, then CSRRS 0x340 with 0x10 and CSRRC 0x340 with 0x0F -> reads return DEAD_BEEF, DEAD_BEFF, DEAD_BEF0.
- CSRRW 0xC00, or CSRRW 0xF14 with 5 -> `csr_illegal` = 1 and no change; CSRRS 0xC00 with operand 0 -> legal, returns the cycle count.
- Write `mcycle` = 32'hFFFF_FFFF and `mcycleh` = 0, then wait 1 cycle -> `mcycleh` = 1 and `mcycle` = 0; with the macro undefined, access to 0xB00 is illegal.
- Set MIE; then `trap_valid` with `trap_pc` 0x1006 and cause 11 -> `mepc` = 0x1004, `mcause` = 11, MIE = 0, MPIE = 1; then `mret` -> MIE = 1.
- `trap_valid`, `mret` and CSRRW `mscratch` in the same cycle -> trap applied, `mscratch` unchanged, `csr_rdata` = old `mscratch`.
